// File: rtl/alu_b_sequencer.sv
// Multi-cycle sequencer for the ALU B-operand mux: one request per transaction, up to
// three ALU phases (PH1, PH2 for LDI16 high byte, INC post-increment). Macro: ALUB_SEQ_B2B_EN.
module alu_b_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [2:0]  REQ_OP,
    input  logic [3:0]  REQ_ARGA,
    input  logic [3:0]  REQ_ARGB,
    input  logic [15:0] REQ_IMM,
    input  logic [1:0]  REQ_INC,
    output logic [2:0]  ALUB_SRCX,
    output logic [3:0]  ARGA_X,
    output logic [3:0]  ARGB_X,
    output logic        ALU_EN,
    input  logic        ALU_ACK,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {IDLE, PH1, PH2, INC, FIN} state_t;

    localparam logic [2:0] SRC_REG_B = 3'd0, SRC_U8H = 3'd1, SRC_U8 = 3'd2,
                           SRC_S8 = 3'd3, SRC_U4 = 3'd4, SRC_U4_0 = 3'd5;
    localparam logic [2:0] OP_REG_B = 3'd0, OP_U4 = 3'd1, OP_U4_0 = 3'd2,
                           OP_S8 = 3'd3, OP_U8 = 3'd4, OP_LDI16 = 3'd5;
    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [2:0]  op_q, op_n;
    logic [3:0]  arga_q, arga_n, argb_q, argb_n;
    logic [15:0] imm_q, imm_n;
    logic [1:0]  inc_q, inc_n;
    logic        accept, timeout, err_d, en_d, ready_d;
    logic [2:0]  srcx_d;
    logic [3:0]  arga_d, argb_d;

    assign accept  = REQ_VALID && REQ_READY;
    assign timeout = (timer_q == TIMER_LAST);

    // Fields used by the output decode: fresh request on accept, captured copy otherwise.
    assign op_n   = accept ? REQ_OP   : op_q;
    assign arga_n = accept ? REQ_ARGA : arga_q;
    assign argb_n = accept ? REQ_ARGB : argb_q;
    assign imm_n  = accept ? REQ_IMM  : imm_q;
    assign inc_n  = accept ? REQ_INC  : inc_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                // Accept in FIN is only reachable when back-to-back ready is built in.
                if (state_q == FIN) state_d = IDLE;
                if (accept) begin
                    if (REQ_OP > OP_LDI16) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = PH1;
                    end
                end
            end
            PH1, PH2, INC: begin
                if (ALU_ACK) begin
                    if (state_q == PH1 && op_q == OP_LDI16) state_d = PH2;
                    else if (state_q != INC && inc_q != 2'b00) state_d = INC;
                    else state_d = FIN;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign timer_d = (state_d == state_q && (state_q == PH1 || state_q == PH2 || state_q == INC))
                     ? timer_q + 8'd1 : 8'd0;

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        srcx_d = SRC_REG_B;
        arga_d = 4'h0;
        argb_d = 4'h0;
        en_d   = 1'b0;
        case (state_d)
            PH1: begin
                en_d = 1'b1;
                case (op_n)
                    OP_U4:    begin srcx_d = SRC_U4;   argb_d = argb_n; end
                    OP_U4_0:  begin srcx_d = SRC_U4_0; argb_d = argb_n; end
                    OP_S8:    begin srcx_d = SRC_S8;   arga_d = arga_n; argb_d = argb_n; end
                    OP_U8:    begin srcx_d = SRC_U8;   arga_d = arga_n; argb_d = argb_n; end
                    OP_LDI16: begin srcx_d = SRC_U8;   arga_d = imm_n[7:4]; argb_d = imm_n[3:0]; end
                    default:  srcx_d = SRC_REG_B;
                endcase
            end
            PH2: begin
                en_d   = 1'b1;
                srcx_d = SRC_U8H;
                arga_d = imm_n[15:12];
                argb_d = imm_n[11:8];
            end
            INC: begin
                en_d = 1'b1;
                case (inc_n)
                    2'b01:   begin srcx_d = SRC_U4;   argb_d = 4'd1; end
                    2'b10:   begin srcx_d = SRC_U4;   argb_d = 4'd2; end
                    default: begin srcx_d = SRC_U4_0; argb_d = 4'd2; end
                endcase
            end
            default: ;
        endcase
    end

`ifdef ALUB_SEQ_B2B_EN
    assign ready_d = (state_d == IDLE) || (state_d == FIN);
`else
    assign ready_d = (state_d == IDLE);
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            timer_q   <= 8'd0;
            ALUB_SRCX <= SRC_REG_B;
            ARGA_X    <= 4'h0;
            ARGB_X    <= 4'h0;
            ALU_EN    <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            REQ_READY <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ALUB_SRCX <= srcx_d;
            ARGA_X    <= arga_d;
            ARGB_X    <= argb_d;
            ALU_EN    <= en_d;
            DONE      <= (state_d == FIN);
            ERR       <= err_d;
            REQ_READY <= ready_d;
        end
    end

    // NOTE: captured request fields are only read after an accept loads them, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_q   <= REQ_OP;
            arga_q <= REQ_ARGA;
            argb_q <= REQ_ARGB;
            imm_q  <= REQ_IMM;
            inc_q  <= REQ_INC;
        end
    end

endmodule
